gate_bist: RTL and testbench

Built-in self-test sequencer for a single 2-input combinational gate, such as the lab AND cell. It drives the gate's two inputs through every truth-table pattern, samples the gate output, and compares it against a parameterised expected truth table. It reports pass/fail, an error count and the first failing pattern. It sits on the stimulus/check side of the gate and replaces the simulation-only toggling stimulus, so the same check runs on the FPGA.

---
 rtl/gate_bist.sv | 161 ++++++++++++++++
 tb/tb_gate_bist.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_bist.sv
// Built-in self-test sequencer for one 2-input combinational gate: sweeps all four
// input patterns, samples the gate output after a dwell, and tallies mismatches.
module gate_bist #(
  parameter int unsigned DWELL  = 4,        // cycles each pattern is held (2..255)
  parameter int unsigned PASSES = 2,        // full 4-pattern sweeps per run (1..255)
  parameter int unsigned ERR_W  = 8,        // error counter width
  parameter logic [3:0]  EXPECT = 4'b1000   // expected output indexed by {stim_2, stim_1}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             dut_out,
  output logic             stim_1,
  output logic             stim_2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [1:0]       first_fail_pattern
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);
  localparam logic [7:0]       PASS_LAST  = 8'(PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_pat;
  logic [7:0]       r_dwell;
  logic [7:0]       r_pass_cnt;
  logic [ERR_W-1:0] r_err;
  logic             r_ff_valid;
  logic [1:0]       r_ff_pat;
  logic             r_stim_1;
  logic             r_stim_2;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic             w_start_acc;
  logic             w_sample;
  logic             w_mismatch;
  logic             w_last;
  logic [ERR_W-1:0] w_err_next;
  logic [1:0]       w_pat_next;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves
  // it unassigned; a missing default would infer a latch.
  always_comb begin
    w_start_acc = start && !abort && (r_state != ST_DRIVE);
    w_sample    = (r_state == ST_DRIVE) && !abort && (r_dwell == DWELL_LAST);
    w_mismatch  = w_sample && (dut_out != EXPECT[r_pat]);
    w_last      = w_sample && (r_pat == 2'd3) && (r_pass_cnt == PASS_LAST);
    w_pat_next  = r_pat + 2'd1;

    // Abort outranks start, and start outranks the end-of-run transition.
    w_next = r_state;
    if (abort) begin
      w_next = ST_IDLE;
    end else if (w_start_acc) begin
      w_next = ST_DRIVE;
    end else if (w_last) begin
      w_next = ST_DONE;
    end

    w_err_next = r_err;
    if (w_start_acc) begin
      w_err_next = '0;
    end else if (w_mismatch && (r_err != ERR_MAX)) begin
      w_err_next = r_err + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat      <= '0;
      r_dwell    <= '0;
      r_pass_cnt <= '0;
      r_err      <= '0;
      r_ff_valid <= 1'b0;
      r_ff_pat   <= '0;
      r_stim_1   <= 1'b0;
      r_stim_2   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      r_err  <= w_err_next;
      r_busy <= (w_next == ST_DRIVE);
      r_done <= (w_next == ST_DONE);
      r_pass <= (w_next == ST_DONE) && (w_err_next == '0);

      if (abort) begin
        // Results are held for inspection; only the sequencing state is parked.
        r_pat      <= '0;
        r_dwell    <= '0;
        r_pass_cnt <= '0;
        r_stim_1   <= 1'b0;
        r_stim_2   <= 1'b0;
      end else if (w_start_acc) begin
        r_pat      <= '0;
        r_dwell    <= '0;
        r_pass_cnt <= '0;
        r_ff_valid <= 1'b0;
        r_ff_pat   <= '0;
        r_stim_1   <= 1'b0;
        r_stim_2   <= 1'b0;
      end else if (r_state == ST_DRIVE) begin
        if (w_sample) begin
          r_dwell <= '0;
          r_pat   <= w_pat_next;
          if (r_pat == 2'd3) begin
            r_pass_cnt <= r_pass_cnt + 8'd1;
          end
          if (w_mismatch && !r_ff_valid) begin
            r_ff_valid <= 1'b1;
            r_ff_pat   <= r_pat;
          end
          // Stims return to 0 together with the move to DONE.
          if (w_last) begin
            r_stim_1 <= 1'b0;
            r_stim_2 <= 1'b0;
          end else begin
            r_stim_1 <= w_pat_next[0];
            r_stim_2 <= w_pat_next[1];
          end
        end else begin
          r_dwell <= r_dwell + 8'd1;
        end
      end
    end
  end

  assign stim_1             = r_stim_1;
  assign stim_2             = r_stim_2;
  assign busy               = r_busy;
  assign done               = r_done;
  assign pass               = r_pass;
  assign err_count          = r_err;
  assign first_fail_valid   = r_ff_valid;
  assign first_fail_pattern = r_ff_pat;

endmodule

// File: tb/tb_gate_bist.sv
// Scoreboard bench for gate_bist: four instances cover AND/stuck-at faults, a narrow
// saturating counter, an OR gate and a gate with one cycle of registered latency.
module tb_gate_bist;

  typedef struct {
    int         inst;
    int         cycles;
    int         err;
    logic       pass;
    logic       ffv;
    logic [1:0] ffp;
  } result_t;

  logic clk;
  logic rst_n;
  logic abort_a;
  logic [3:0] start_v;
  int   mode_a;   // 0 = AND, 1 = stuck-at-0, 2 = stuck-at-1

  logic [3:0] s1_v, s2_v, busy_v, done_v, pass_v, ffv_v;
  logic [1:0] ffp_v [4];
  logic [7:0] err_v [4];
  logic [7:0] err_a;
  logic [1:0] err_b;
  logic [7:0] err_c, err_d;
  logic dut_a, dut_b, dut_c, dut_d;

  result_t exp_q[$];
  int n_cmp;
  int n_fail;
  int cnt [4];
  int bad [4];
  logic [3:0] prev_busy, prev_done;
  int dwell_v [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (mode_a)
      1:       dut_a = 1'b0;
      2:       dut_a = 1'b1;
      default: dut_a = s1_v[0] & s2_v[0];
    endcase
  end
  assign dut_b = 1'b1;
  assign dut_c = s1_v[2] | s2_v[2];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) dut_d <= 1'b0;
    else        dut_d <= s1_v[3] & s2_v[3];
  end

  gate_bist u_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_a), .dut_out(dut_a),
    .stim_1(s1_v[0]), .stim_2(s2_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .err_count(err_a), .first_fail_valid(ffv_v[0]), .first_fail_pattern(ffp_v[0]));

  gate_bist #(.ERR_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(1'b0), .dut_out(dut_b),
    .stim_1(s1_v[1]), .stim_2(s2_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .err_count(err_b), .first_fail_valid(ffv_v[1]), .first_fail_pattern(ffp_v[1]));

  gate_bist #(.DWELL(2), .PASSES(1), .EXPECT(4'b1110)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(1'b0), .dut_out(dut_c),
    .stim_1(s1_v[2]), .stim_2(s2_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .err_count(err_c), .first_fail_valid(ffv_v[2]), .first_fail_pattern(ffp_v[2]));

  gate_bist #(.DWELL(2)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .abort(1'b0), .dut_out(dut_d),
    .stim_1(s1_v[3]), .stim_2(s2_v[3]), .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]),
    .err_count(err_d), .first_fail_valid(ffv_v[3]), .first_fail_pattern(ffp_v[3]));

  assign err_v[0] = err_a;
  assign err_v[1] = {6'd0, err_b};
  assign err_v[2] = err_c;
  assign err_v[3] = err_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_run(input int inst, input int cycles, input int err,
                            input logic p, input logic v, input logic [1:0] fp);
    result_t r;
    r.inst = inst; r.cycles = cycles; r.err = err; r.pass = p; r.ffv = v; r.ffp = fp;
    exp_q.push_back(r);
  endtask

  task automatic pulse_start(input int k);
    @(negedge clk);
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v = '0;
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 1000) begin
      @(negedge clk);
      b++;
    end
    check("run_completion_timeout", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
  endtask

  // Monitor: counts busy cycles, checks the stim walk, and scores each run at done.
  always @(negedge clk) begin
    int      exp_pat;
    result_t e;
    string   t;
    for (int k = 0; k < 4; k++) begin
      t = $sformatf("inst%0d", k);
      if (busy_v[k]) begin
        if (!prev_busy[k]) begin
          cnt[k] = 0;
          bad[k] = 0;
        end
        cnt[k]++;
        exp_pat = ((cnt[k] - 1) / dwell_v[k]) % 4;
        if ({s2_v[k], s1_v[k]} != 2'(exp_pat)) bad[k]++;
      end
      if (done_v[k] && !prev_done[k]) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL %s_unexpected_done: got done=1, expected no run end", t);
        end else begin
          e = exp_q.pop_front();
          check({t, "_instance"}, k, e.inst);
          check({t, "_busy_cycles"}, cnt[k], e.cycles);
          check({t, "_stim_walk_errors"}, bad[k], 0);
          check({t, "_err_count"}, err_v[k], e.err);
          check({t, "_pass"}, pass_v[k], e.pass);
          check({t, "_first_fail_valid"}, ffv_v[k], e.ffv);
          if (e.ffv) check({t, "_first_fail_pattern"}, ffp_v[k], e.ffp);
          check({t, "_done_stims_busy"}, {s2_v[k], s1_v[k], busy_v[k]}, 0);
        end
      end
      prev_busy[k] = busy_v[k];
      prev_done[k] = done_v[k];
    end
  end

  function automatic logic [31:0] outs_a();
    return {18'd0, s1_v[0], s2_v[0], busy_v[0], done_v[0], pass_v[0], err_a, ffv_v[0], ffp_v[0]};
  endfunction

  initial begin
    n_cmp = 0; n_fail = 0;
    dwell_v = '{4, 4, 2, 2};
    prev_busy = '0; prev_done = '0;
    start_v = '0; abort_a = 1'b0; mode_a = 0;
    rst_n = 1'b0;
    #1;
    check("reset_outputs", outs_a(), 0);
    check("reset_outputs_all_busy_done", {busy_v, done_v}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Correct AND gate, then stuck-at-0, then stuck-at-1 (each started from DONE).
    expect_run(0, 32, 0, 1'b1, 1'b0, 2'd0);
    pulse_start(0);
    wait_drain();
    mode_a = 1;
    expect_run(0, 32, 2, 1'b0, 1'b1, 2'd3);
    pulse_start(0);
    wait_drain();
    mode_a = 2;
    expect_run(0, 32, 6, 1'b0, 1'b1, 2'd0);
    pulse_start(0);
    wait_drain();

    // Stuck-at-1 with a 2-bit counter: six mismatches saturate at 3.
    expect_run(1, 32, 3, 1'b0, 1'b1, 2'd0);
    pulse_start(1);
    wait_drain();

    // OR gate, DWELL=2, PASSES=1; AND with one cycle of latency, DWELL=2.
    expect_run(2, 8, 0, 1'b1, 1'b0, 2'd0);
    pulse_start(2);
    wait_drain();
    expect_run(3, 16, 0, 1'b1, 1'b0, 2'd0);
    pulse_start(3);
    wait_drain();

    // start while busy is ignored.
    mode_a = 0;
    expect_run(0, 32, 0, 1'b1, 1'b0, 2'd0);
    pulse_start(0);
    repeat (10) @(negedge clk);
    pulse_start(0);
    wait_drain();

    // Abort sampled at cycle 10 of a stuck-at-1 run: samples at cycles 4 and 8 failed.
    mode_a = 2;
    pulse_start(0);
    repeat (9) @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check("abort_busy_done_stims", {busy_v[0], done_v[0], s1_v[0], s2_v[0]}, 0);
    check("abort_holds_err_count", err_a, 2);
    check("abort_holds_first_fail", {ffv_v[0], ffp_v[0]}, 3'b100);
    repeat (3) @(negedge clk);
    check("abort_stays_idle", busy_v[0], 0);
    mode_a = 0;
    expect_run(0, 32, 0, 1'b1, 1'b0, 2'd0);
    pulse_start(0);
    check("restart_clears_results", {err_a, ffv_v[0]}, 0);
    wait_drain();

    // Asynchronous reset between clock edges in the middle of a failing run.
    mode_a = 2;
    pulse_start(0);
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", outs_a(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mode_a = 0;
    expect_run(0, 32, 0, 1'b1, 1'b0, 2'd0);
    pulse_start(0);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
